// File: rtl/alu_cond_unit_pkg.sv
// Shared types for the integer ALU functional unit.
//   fu_op_t      : ALU operation selector (values 13..15 are unused encodings)
//   cond_t       : AArch64 condition code, EQ=0 .. NV=15
//   nzcv_t       : flags, N in msb .. V in lsb
//   rs_if_t      : issue bundle from the reservation station
//   rs_alu_ext_t : ALU-specific issue extension (flag write enable, flags, condition)
//   fu_if_t      : completion bundle to the ROB
//   fu_alu_ext_t : ALU-specific completion extension
package alu_cond_unit_pkg;

  localparam int unsigned GPR_SIZE  = 64;
  localparam int unsigned ROB_IDX_W = 4;

  typedef enum logic [3:0] {
    FU_OP_PASS_A = 4'd0,
    FU_OP_PLUS   = 4'd1,
    FU_OP_MINUS  = 4'd2,
    FU_OP_AND    = 4'd3,
    FU_OP_OR     = 4'd4,
    FU_OP_ORN    = 4'd5,
    FU_OP_EOR    = 4'd6,
    FU_OP_CSEL   = 4'd7,
    FU_OP_CSINC  = 4'd8,
    FU_OP_CSINV  = 4'd9,
    FU_OP_CSNEG  = 4'd10,
    FU_OP_ADRX   = 4'd11,
    FU_OP_MOV    = 4'd12
  } fu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic                 start;
    fu_op_t               fu_op;
    logic [GPR_SIZE-1:0]  val_a;
    logic [GPR_SIZE-1:0]  val_b;
    logic [ROB_IDX_W-1:0] dst_rob_index;
  } rs_if_t;

  typedef struct packed {
    logic  set_nzcv;
    nzcv_t nzcv;
    cond_t cond_codes;
  } rs_alu_ext_t;

  typedef struct packed {
    logic                 done;
    logic [ROB_IDX_W-1:0] dst_rob_index;
    logic [GPR_SIZE-1:0]  value;
  } fu_if_t;

  typedef struct packed {
    logic  set_nzcv;
    nzcv_t nzcv;
    logic  condition;
  } fu_alu_ext_t;

endpackage

// File: rtl/alu_cond_unit_cond_holds.sv
// Combinational AArch64 condition evaluation.
//   cond       : in  condition code
//   nzcv       : in  flags to test
//   cond_holds : out 1 when the condition is satisfied
module cond_holds
  import alu_cond_unit_pkg::*;
(
  input  cond_t cond,
  input  nzcv_t nzcv,
  output logic  cond_holds
);

  logic [2:0] sel;
  logic       base;

  always_comb begin
    sel  = cond[3:1];
    base = 1'b0;
    case (sel)
      3'b000: base = nzcv.z;
      3'b001: base = nzcv.c;
      3'b010: base = nzcv.n;
      3'b011: base = nzcv.v;
      3'b100: base = nzcv.c & ~nzcv.z;
      3'b101: base = (nzcv.n == nzcv.v);
      3'b110: base = (nzcv.n == nzcv.v) & ~nzcv.z;
      default: base = 1'b1;
    endcase
    // Odd codes invert the base test, but NV (1111) behaves like AL.
    cond_holds = (cond == COND_NV) ? 1'b1 : (base ^ cond[0]);
  end

endmodule

// File: rtl/alu_cond_unit.sv
// Single-issue integer ALU functional unit, latency 1.
//   in_clk             : clock, all state on posedge
//   in_rst             : synchronous active-low reset
//   in_rs_alu_sigs     : start, fu_op, val_a, val_b, dst_rob_index
//   in_rs_alu_sigs_ext : set_nzcv, nzcv, cond_codes
//   out_rs_alu_ready   : constant 1, one op accepted per cycle
//   out_rob_sigs       : done (one-cycle pulse), dst_rob_index, value
//   out_rob_alu_sigs   : set_nzcv, nzcv, condition
module alu_cond_unit
  import alu_cond_unit_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_rst,
  input  rs_if_t      in_rs_alu_sigs,
  input  rs_alu_ext_t in_rs_alu_sigs_ext,
  output logic        out_rs_alu_ready,
  output fu_if_t      out_rob_sigs,
  output fu_alu_ext_t out_rob_alu_sigs
);

  logic                 start_q, start_d;
  fu_op_t               op_q, op_d;
  logic [GPR_SIZE-1:0]  val_a_q, val_a_d;
  logic [GPR_SIZE-1:0]  val_b_q, val_b_d;
  logic [ROB_IDX_W-1:0] dst_q, dst_d;
  logic                 set_nzcv_q, set_nzcv_d;
  nzcv_t                nzcv_q, nzcv_d;
  cond_t                cond_q, cond_d;

  always_comb begin
    start_d    = in_rs_alu_sigs.start;
    op_d       = op_q;
    val_a_d    = val_a_q;
    val_b_d    = val_b_q;
    dst_d      = dst_q;
    set_nzcv_d = set_nzcv_q;
    nzcv_d     = nzcv_q;
    cond_d     = cond_q;
    if (in_rs_alu_sigs.start) begin
      op_d       = in_rs_alu_sigs.fu_op;
      val_a_d    = in_rs_alu_sigs.val_a;
      val_b_d    = in_rs_alu_sigs.val_b;
      dst_d      = in_rs_alu_sigs.dst_rob_index;
      set_nzcv_d = in_rs_alu_sigs_ext.set_nzcv;
      nzcv_d     = in_rs_alu_sigs_ext.nzcv;
      cond_d     = in_rs_alu_sigs_ext.cond_codes;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      start_q    <= 1'b0;
      op_q       <= FU_OP_PASS_A;
      val_a_q    <= '0;
      val_b_q    <= '0;
      dst_q      <= '0;
      set_nzcv_q <= 1'b0;
      nzcv_q     <= '0;
      cond_q     <= COND_EQ;
    end else begin
      start_q    <= start_d;
      op_q       <= op_d;
      val_a_q    <= val_a_d;
      val_b_q    <= val_b_d;
      dst_q      <= dst_d;
      set_nzcv_q <= set_nzcv_d;
      nzcv_q     <= nzcv_d;
      cond_q     <= cond_d;
    end
  end

  logic cond_ok;

  cond_holds u_cond_holds (
    .cond       (cond_q),
    .nzcv       (nzcv_q),
    .cond_holds (cond_ok)
  );

  // One shared adder; subtraction is a + ~b + 1 so the carry-out is "no borrow".
  logic                is_sub;
  logic [GPR_SIZE-1:0] add_b;
  logic [GPR_SIZE:0]   sum;
  logic [GPR_SIZE-1:0] result;
  nzcv_t               flags;

  always_comb begin
    is_sub = (op_q == FU_OP_MINUS);
    add_b  = is_sub ? ~val_b_q : val_b_q;
    sum    = {1'b0, val_a_q} + {1'b0, add_b} + {{GPR_SIZE{1'b0}}, is_sub};

    case (op_q)
      FU_OP_PLUS, FU_OP_ADRX, FU_OP_MINUS: result = sum[GPR_SIZE-1:0];
      FU_OP_AND:    result = val_a_q & val_b_q;
      FU_OP_OR,
      FU_OP_MOV:    result = val_a_q | val_b_q;
      FU_OP_ORN:    result = val_a_q | ~val_b_q;
      FU_OP_EOR:    result = val_a_q ^ val_b_q;
      FU_OP_PASS_A: result = val_a_q;
      FU_OP_CSEL:   result = cond_ok ? val_a_q : val_b_q;
      FU_OP_CSINC:  result = cond_ok ? val_a_q : (val_b_q + GPR_SIZE'(1));
      FU_OP_CSINV:  result = cond_ok ? val_a_q : ~val_b_q;
      FU_OP_CSNEG:  result = cond_ok ? val_a_q : ('0 - val_b_q);
      default:      result = '0;
    endcase

    flags.n = result[GPR_SIZE-1];
    flags.z = (result == '0);
    flags.c = 1'b0;
    flags.v = 1'b0;
    case (op_q)
      FU_OP_PLUS, FU_OP_ADRX: begin
        flags.c = sum[GPR_SIZE];
        flags.v = (val_a_q[GPR_SIZE-1] == val_b_q[GPR_SIZE-1]) &&
                  (result[GPR_SIZE-1] != val_a_q[GPR_SIZE-1]);
      end
      FU_OP_MINUS: begin
        flags.c = sum[GPR_SIZE];
        flags.v = (val_a_q[GPR_SIZE-1] != val_b_q[GPR_SIZE-1]) &&
                  (result[GPR_SIZE-1] != val_a_q[GPR_SIZE-1]);
      end
      default: ;
    endcase
  end

  assign out_rs_alu_ready               = 1'b1;
  assign out_rob_sigs.done              = start_q;
  assign out_rob_sigs.dst_rob_index     = dst_q;
  assign out_rob_sigs.value             = result;
  assign out_rob_alu_sigs.set_nzcv      = set_nzcv_q;
  assign out_rob_alu_sigs.nzcv          = flags;
  assign out_rob_alu_sigs.condition     = cond_ok;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Self-checking bench for alu_cond_unit: vector table, condition sweep,
// reset corner cases; expectations flow through a scoreboard queue.
module tb_alu_cond_unit;
  import alu_cond_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  rs_if_t      rs;
  rs_alu_ext_t rs_ext;
  logic        ready;
  fu_if_t      rob;
  fu_alu_ext_t rob_ext;

  always #5 clk = ~clk;

  alu_cond_unit dut (
    .in_clk             (clk),
    .in_rst             (rst_n),
    .in_rs_alu_sigs     (rs),
    .in_rs_alu_sigs_ext (rs_ext),
    .out_rs_alu_ready   (ready),
    .out_rob_sigs       (rob),
    .out_rob_alu_sigs   (rob_ext)
  );

  typedef struct {
    fu_op_t      op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  cond;
    logic [3:0]  nz_in;
    logic        set;
    logic [3:0]  dst;
    logic [63:0] ev;
    logic [3:0]  en;
    logic        ec;
  } vec_t;

  typedef struct {
    logic [63:0] ev;
    logic [3:0]  en;
    logic        ec;
    logic        set;
    logic [3:0]  dst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent per-code condition table.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic vec_t mk(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] cond, input logic [3:0] nz_in,
                              input logic set, input logic [3:0] dst,
                              input logic [63:0] ev, input logic [3:0] en, input logic ec);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cond = cond; v.nz_in = nz_in;
    v.set = set; v.dst = dst; v.ev = ev; v.en = en; v.ec = ec;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    rs.start         = 1'b1;
    rs.fu_op         = v.op;
    rs.val_a         = v.a;
    rs.val_b         = v.b;
    rs.dst_rob_index = v.dst;
    rs_ext.set_nzcv  = v.set;
    rs_ext.nzcv      = v.nz_in;
    rs_ext.cond_codes = cond_t'(v.cond);
    e.ev = v.ev; e.en = v.en; e.ec = v.ec; e.set = v.set; e.dst = v.dst;
    sb.push_back(e);
  endtask

  // Output monitor: every done pulse must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (rob.done) begin
      if (sb.size() == 0) begin
        check("stray_done", 64'(rob.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("value", rob.value, e.ev);
        check("nzcv", 64'(rob_ext.nzcv), 64'(e.en));
        check("condition", 64'(rob_ext.condition), 64'(e.ec));
        check("set_nzcv", 64'(rob_ext.set_nzcv), 64'(e.set));
        check("dst", 64'(rob.dst_rob_index), 64'(e.dst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 64'(rob.done), 64'd0);
    check({tag, "_value"}, rob.value, 64'd0);
    check({tag, "_dst"}, 64'(rob.dst_rob_index), 64'd0);
    check({tag, "_set"}, 64'(rob_ext.set_nzcv), 64'd0);
    check({tag, "_nzcv"}, 64'(rob_ext.nzcv), 64'b0100);
    check({tag, "_cond"}, 64'(rob_ext.condition), 64'd0);
  endtask

  vec_t vt[17];

  initial begin
    vt[0]  = mk(FU_OP_PLUS,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0,  4'b0000, 1'b1, 4'd3,
                64'd0, 4'b0110, 1'b0);
    vt[1]  = mk(FU_OP_MINUS, 64'd5, 64'd7, 4'd14, 4'b0000, 1'b0, 4'd1,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1);
    vt[2]  = mk(FU_OP_MINUS, 64'd7, 64'd5, 4'd14, 4'b0000, 1'b1, 4'd2,
                64'd2, 4'b0010, 1'b1);
    vt[3]  = mk(FU_OP_PLUS,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd14, 4'b0000, 1'b0, 4'd3,
                64'h8000_0000_0000_0000, 4'b1001, 1'b1);
    vt[4]  = mk(FU_OP_CSEL,  64'd10, 64'd20, 4'd10, 4'b1001, 1'b1, 4'd4,
                64'd10, 4'b0000, 1'b1);
    vt[5]  = mk(FU_OP_CSNEG, 64'd10, 64'd20, 4'd0, 4'b0000, 1'b0, 4'd5,
                64'hFFFF_FFFF_FFFF_FFEC, 4'b1000, 1'b0);
    vt[6]  = mk(FU_OP_CSINC, 64'd1, 64'd41, 4'd1, 4'b0100, 1'b1, 4'd6,
                64'd42, 4'b0000, 1'b0);
    vt[7]  = mk(FU_OP_CSINV, 64'h55, 64'd0, 4'd11, 4'b0000, 1'b0, 4'd7,
                64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
    vt[8]  = mk(FU_OP_AND,   64'hF0F0, 64'hFF00, 4'd14, 4'b0000, 1'b1, 4'd8,
                64'hF000, 4'b0000, 1'b1);
    vt[9]  = mk(FU_OP_MOV,   64'd0, 64'd0, 4'd14, 4'b0000, 1'b0, 4'd9,
                64'd0, 4'b0100, 1'b1);
    vt[10] = mk(FU_OP_ORN,   64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 4'd14, 4'b0000, 1'b1, 4'd10,
                64'hF, 4'b0000, 1'b1);
    vt[11] = mk(FU_OP_EOR,   64'h1234, 64'h1234, 4'd14, 4'b0000, 1'b0, 4'd11,
                64'd0, 4'b0100, 1'b1);
    vt[12] = mk(FU_OP_ADRX,  64'h1000, 64'h20, 4'd14, 4'b0000, 1'b1, 4'd12,
                64'h1020, 4'b0000, 1'b1);
    vt[13] = mk(fu_op_t'(4'd15), 64'd5, 64'd6, 4'd14, 4'b0000, 1'b0, 4'd13,
                64'd0, 4'b0100, 1'b1);
    vt[14] = mk(FU_OP_MINUS, 64'h8000_0000_0000_0000, 64'd1, 4'd14, 4'b0000, 1'b1, 4'd14,
                64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1);
    vt[15] = mk(FU_OP_MINUS, 64'd9, 64'd9, 4'd14, 4'b0000, 1'b0, 4'd15,
                64'd0, 4'b0110, 1'b1);
    vt[16] = mk(FU_OP_OR,    64'h8000_0000_0000_0000, 64'd0, 4'd14, 4'b0000, 1'b1, 4'd0,
                64'h8000_0000_0000_0000, 4'b1000, 1'b1);

    rs = '0;
    rs_ext = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("ready", 64'(ready), 64'd1);
    rst_n = 1'b1;

    // Back-to-back table vectors.
    for (int i = 0; i < 17; i++) issue(vt[i]);
    @(negedge clk);
    rs.start = 1'b0;

    // Condition sweep: all codes against all flag patterns.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        issue(mk(FU_OP_PASS_A, 64'd0, 64'd0, 4'(c), 4'(f), 1'b0, 4'(f),
                 64'd0, 4'b0100, model_cond(4'(c), 4'(f))));
      end
    end
    @(negedge clk);
    rs.start = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);

    // Reset must win over a simultaneous start.
    issue(mk(FU_OP_PLUS, 64'd1, 64'd2, 4'd14, 4'b0000, 1'b1, 4'd9, 64'd3, 4'b0000, 1'b1));
    @(negedge clk);
    rs.fu_op = FU_OP_PASS_A;
    rs.val_a = 64'hDEAD;
    rs.dst_rob_index = 4'd7;
    rs_ext.set_nzcv = 1'b1;
    rs_ext.nzcv = 4'b1111;
    rs.start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_vs_start");
    rst_n = 1'b1;
    rs.start = 1'b0;
    @(negedge clk);
    check("post_rst_done0", 64'(rob.done), 64'd0);
    @(negedge clk);
    check("post_rst_done1", 64'(rob.done), 64'd0);
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
